// File: rtl/sdram_line_adapter.sv
// sdram_line_adapter: turns one 128-bit cache-line read/write into a single
// 8-beat sequential SDRAM burst and reassembles read beats into a line.
// Only one request is in flight at a time. Controller handshake violations
// latch into err_sticky and do not stop the FSM.
module sdram_line_adapter #(
    parameter  int unsigned DATA_W    = 16,
    parameter  int unsigned BURST_LEN = 8,
    parameter  int unsigned ADDR_W    = 25,
    localparam int unsigned LINE_W    = DATA_W * BURST_LEN
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_rw,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [LINE_W-1:0] core_req_wr_line,
    output logic              core_rsp_valid,
    input  logic              core_rsp_ready,
    output logic              core_rsp_rw,
    output logic [LINE_W-1:0] core_rsp_rd_line,
    output logic              ctrl_req_valid,
    input  logic              ctrl_req_ready,
    output logic              ctrl_rw,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wr_data,
    input  logic              ctrl_wr_beat,
    input  logic              ctrl_rd_valid,
    input  logic [DATA_W-1:0] ctrl_rd_data,
    input  logic              ctrl_done,
    output logic              err_sticky
);

    localparam int unsigned       CNT_W      = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WR_BEATS,
        S_RD_BEATS,
        S_WAIT_DONE,
        S_RESP
    } stateT;

    stateT             state;
    logic [CNT_W-1:0]  cnt;
    logic              lastBeat;
    logic              doneSeen;
    logic [LINE_W-1:0] lineLatch;

    logic inBeats;
    logic beatHit;
    logic finalBeat;
    logic protoErr;

    // Beat qualification; lastBeat guards against any beat after the eighth.
    assign inBeats   = (state == S_WR_BEATS) || (state == S_RD_BEATS);
    assign beatHit   = !lastBeat &&
                       (((state == S_WR_BEATS) && ctrl_wr_beat) ||
                        ((state == S_RD_BEATS) && ctrl_rd_valid));
    assign finalBeat = beatHit && (cnt == LAST_CNT);

    // Controller-side protocol violations.
    assign protoErr = (ctrl_rd_valid && (state != S_RD_BEATS)) ||
                      (ctrl_wr_beat  && (state != S_WR_BEATS)) ||
                      (ctrl_done && ((state == S_ISSUE) || (state == S_RESP))) ||
                      (ctrl_done && inBeats && !finalBeat);

    // Current write beat is selected straight from the latched line by cnt.
    assign ctrl_wr_data = lineLatch[DATA_W * 32'(cnt) +: DATA_W];

    // Request/burst/response sequencing with registered handshake outputs.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            lastBeat         <= 1'b0;
            doneSeen         <= 1'b0;
            lineLatch        <= '0;
            core_req_ready   <= 1'b1;
            core_rsp_valid   <= 1'b0;
            core_rsp_rw      <= 1'b0;
            core_rsp_rd_line <= '0;
            ctrl_req_valid   <= 1'b0;
            ctrl_rw          <= 1'b0;
            ctrl_addr        <= '0;
            err_sticky       <= 1'b0;
        end else begin
            if (protoErr) begin
                err_sticky <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (core_req_valid && core_req_ready) begin
                        ctrl_rw        <= core_req_rw;
                        ctrl_addr      <= core_req_addr & ALIGN_MASK;
                        lineLatch      <= core_req_wr_line;
                        core_req_ready <= 1'b0;
                        ctrl_req_valid <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ctrl_req_ready) begin
                        ctrl_req_valid <= 1'b0;
                        cnt            <= '0;
                        lastBeat       <= 1'b0;
                        doneSeen       <= 1'b0;
                        state          <= ctrl_rw ? S_WR_BEATS : S_RD_BEATS;
                    end
                end
                S_WR_BEATS, S_RD_BEATS: begin
                    if (ctrl_done) begin
                        doneSeen <= 1'b1;
                    end
                    if (beatHit) begin
                        cnt <= cnt + CNT_W'(1);
                        if (state == S_RD_BEATS) begin
                            core_rsp_rd_line[DATA_W * 32'(cnt) +: DATA_W] <= ctrl_rd_data;
                        end
                    end
                    if (finalBeat) begin
                        lastBeat <= 1'b1;
                        if (doneSeen || ctrl_done) begin
                            core_rsp_valid <= 1'b1;
                            core_rsp_rw    <= ctrl_rw;
                            state          <= S_RESP;
                        end else begin
                            state <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (ctrl_done) begin
                        core_rsp_valid <= 1'b1;
                        core_rsp_rw    <= ctrl_rw;
                        state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (core_rsp_ready) begin
                        core_rsp_valid <= 1'b0;
                        core_req_ready <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_line_adapter.sv
// Bench for sdram_line_adapter: acts as both the core and the SDRAM
// controller, and compares every cycle against a transaction-level model.
module tb_sdram_line_adapter;

    logic         Clock;
    logic         Rst;
    logic         cReqValid = 1'b0;
    logic         cRw       = 1'b0;
    logic [24:0]  cAddr     = '0;
    logic [127:0] cLine     = '0;
    logic         cRspReady = 1'b0;
    logic         kReqReady = 1'b0;
    logic         kWrBeat   = 1'b0;
    logic         kRdValid  = 1'b0;
    logic [15:0]  kRdData   = '0;
    logic         kDone     = 1'b0;

    logic         coreReqReady;
    logic         coreRspValid;
    logic         coreRspRw;
    logic [127:0] coreRspRdLine;
    logic         ctrlReqValid;
    logic         ctrlRw;
    logic [24:0]  ctrlAddr;
    logic [15:0]  ctrlWrData;
    logic         errSticky;

    int nChecks = 0;
    int nErrors = 0;

    sdram_line_adapter dut (
        .Clock            (Clock),
        .Rst              (Rst),
        .core_req_valid   (cReqValid),
        .core_req_ready   (coreReqReady),
        .core_req_rw      (cRw),
        .core_req_addr    (cAddr),
        .core_req_wr_line (cLine),
        .core_rsp_valid   (coreRspValid),
        .core_rsp_ready   (cRspReady),
        .core_rsp_rw      (coreRspRw),
        .core_rsp_rd_line (coreRspRdLine),
        .ctrl_req_valid   (ctrlReqValid),
        .ctrl_req_ready   (kReqReady),
        .ctrl_rw          (ctrlRw),
        .ctrl_addr        (ctrlAddr),
        .ctrl_wr_data     (ctrlWrData),
        .ctrl_wr_beat     (kWrBeat),
        .ctrl_rd_valid    (kRdValid),
        .ctrl_rd_data     (kRdData),
        .ctrl_done        (kDone),
        .err_sticky       (errSticky)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase flags, beat count, shift-in line assembly.
    bit           mActive = 1'b0;
    bit           mReq    = 1'b0;
    bit           mRsp    = 1'b0;
    bit           mDone   = 1'b0;
    bit           mErr    = 1'b0;
    bit           mRw     = 1'b0;
    bit           mWant   = 1'b0;
    int           mBeats  = 0;
    logic [24:0]  mAddr   = '0;
    logic [127:0] mLine   = '0;
    logic [127:0] mAsm    = '0;
    logic [127:0] mRdLine = '0;

    initial forever begin
        @(posedge Clock or posedge Rst);
        if (Rst) begin
            mActive = 0; mReq = 0; mRsp = 0; mDone = 0; mErr = 0; mRw = 0;
            mBeats = 0; mAddr = '0; mLine = '0; mAsm = '0; mRdLine = '0;
        end else begin
            mWant = mActive && !mReq && !mRsp && (mBeats < 8);
            if (kRdValid && !(mWant && !mRw)) mErr = 1;
            if (kWrBeat && !(mWant && mRw)) mErr = 1;
            if (kDone && (mReq || mRsp)) mErr = 1;
            if (!mActive) begin
                if (cReqValid) begin
                    mActive = 1; mReq = 1; mRw = cRw;
                    mAddr = cAddr & ~25'h7; mLine = cLine;
                end
            end else if (mReq) begin
                if (kReqReady) begin
                    mReq = 0; mBeats = 0; mDone = 0;
                end
            end else if (mRsp) begin
                if (cRspReady) begin
                    mRsp = 0; mActive = 0;
                end
            end else begin
                if (mWant && (mRw ? kWrBeat : kRdValid)) begin
                    mBeats++;
                    if (!mRw) mAsm = {kRdData, mAsm[127:16]};
                end
                if (kDone) begin
                    if (mBeats < 8) mErr = 1;
                    mDone = 1;
                end
                if (mBeats == 8 && mDone) begin
                    mRsp = 1;
                    if (!mRw) mRdLine = mAsm;
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial forever begin
        @(negedge Clock);
        check("req_ready", 128'(coreReqReady), 128'(!mActive));
        check("ctrl_req_valid", 128'(ctrlReqValid), 128'(mReq));
        if (mReq) begin
            check("ctrl_addr", 128'(ctrlAddr), 128'(mAddr));
            check("ctrl_rw", 128'(ctrlRw), 128'(mRw));
        end
        check("rsp_valid", 128'(coreRspValid), 128'(mRsp));
        if (mRsp) begin
            check("rsp_rw", 128'(coreRspRw), 128'(mRw));
            check("rsp_rd_line", coreRspRdLine, mRdLine);
        end
        if (mActive && !mReq && !mRsp && mRw && mBeats < 8)
            check("wr_data", 128'(ctrlWrData), 128'(mLine[16*mBeats +: 16]));
        check("err_sticky", 128'(errSticky), 128'(mErr));
    end

    task automatic cyc();
        @(negedge Clock);
        #1;
    endtask

    task automatic noise(input bit junk);
        if (junk) begin
            cReqValid = 1'($urandom);
            cRw       = 1'($urandom);
            cAddr     = 25'($urandom);
            cLine     = {$urandom(), $urandom(), $urandom(), $urandom()};
            kRdData   = 16'($urandom);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_req_ready"}, 128'(coreReqReady), 128'(1));
        check({tag, "_rsp_valid"}, 128'(coreRspValid), 128'(0));
        check({tag, "_rsp_rw"}, 128'(coreRspRw), 128'(0));
        check({tag, "_rd_line"}, coreRspRdLine, 128'(0));
        check({tag, "_ctrl_valid"}, 128'(ctrlReqValid), 128'(0));
        check({tag, "_ctrl_rw"}, 128'(ctrlRw), 128'(0));
        check({tag, "_ctrl_addr"}, 128'(ctrlAddr), 128'(0));
        check({tag, "_wr_data"}, 128'(ctrlWrData), 128'(0));
        check({tag, "_err"}, 128'(errSticky), 128'(0));
    endtask

    // doneMode: 0 = done with 8th beat, 1 = done doneDly cycles after it,
    // 2 = early done after the 3rd beat.
    task automatic txn(input logic rw, input logic [24:0] addr, input logic [127:0] line,
                       input logic [127:0] rdLine, input int reqDly, input int rspDly,
                       input int doneMode, input int doneDly, input int gapMax,
                       input bit junk, input bit lit, input logic [24:0] litAddr);
        cReqValid = 1'b1; cRw = rw; cAddr = addr; cLine = line;
        cyc();
        cReqValid = 1'b0;
        if (lit) begin
            check("lit_ctrl_valid", 128'(ctrlReqValid), 128'(1));
            check("lit_ctrl_addr", 128'(ctrlAddr), 128'(litAddr));
        end
        for (int i = 0; i < reqDly; i++) begin noise(junk); cyc(); end
        noise(junk); kReqReady = 1'b1; cyc(); kReqReady = 1'b0;
        for (int b = 0; b < 8; b++) begin
            int g;
            g = $urandom_range(gapMax, 0);
            for (int i = 0; i < g; i++) begin noise(junk); cyc(); end
            noise(junk);
            if (rw) begin
                kWrBeat = 1'b1;
                if (lit) check("lit_wr_data", 128'(ctrlWrData), 128'(line[16*b +: 16]));
            end else begin
                kRdValid = 1'b1; kRdData = rdLine[16*b +: 16];
            end
            kDone = (b == 7) && (doneMode == 0);
            cyc();
            kWrBeat = 1'b0; kRdValid = 1'b0; kDone = 1'b0;
            if (b == 2 && doneMode == 2) begin
                noise(junk); kDone = 1'b1; cyc(); kDone = 1'b0;
            end
        end
        if (doneMode == 1) begin
            for (int i = 0; i < doneDly; i++) begin noise(junk); cyc(); end
            noise(junk); kDone = 1'b1; cyc(); kDone = 1'b0;
        end
        if (lit) begin
            check("lit_rsp_valid", 128'(coreRspValid), 128'(1));
            check("lit_rsp_rw", 128'(coreRspRw), 128'(rw));
            if (!rw) check("lit_rd_line", coreRspRdLine, rdLine);
        end
        for (int i = 0; i < rspDly; i++) begin noise(junk); cyc(); end
        noise(junk); cRspReady = 1'b1; cyc();
        cRspReady = 1'b0; cReqValid = 1'b0;
    endtask

    localparam logic [127:0] LINE_K = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    localparam logic [127:0] LINE_A = 128'hA007_A006_A005_A004_A003_A002_A001_A000;

    initial begin
        Rst = 1'b1;
        #12;
        checkReset("reset");
        cyc();
        Rst = 1'b0;
        cyc();

        // Directed write, beat k = k.
        txn(1'b1, 25'h0123457, LINE_K, '0, 0, 0, 1, 1, 0, 1'b0, 1'b1, 25'h0123450);
        check("write_err", 128'(errSticky), 128'(0));
        // Directed read with 0-2 cycle beat gaps.
        txn(1'b0, 25'h1ABCDEF, '0, LINE_A, 0, 0, 1, 0, 2, 1'b0, 1'b1, 25'h1ABCDE8);
        // Done coinciding with the 8th read beat.
        txn(1'b0, 25'h0000010, '0, ~LINE_A, 0, 0, 0, 0, 1, 1'b0, 1'b1, 25'h0000010);
        // Backpressure on both handshakes.
        txn(1'b0, 25'h0F0F0F3, '0, LINE_K ^ LINE_A, 5, 4, 1, 2, 1, 1'b1, 1'b1, 25'h0F0F0F0);

        // Protocol errors: stray read beat while idle, then early done.
        kRdValid = 1'b1; kRdData = 16'hDEAD; cyc(); kRdValid = 1'b0;
        check("err_idle_rd", 128'(errSticky), 128'(1));
        txn(1'b1, 25'h0000100, LINE_A, '0, 1, 1, 2, 0, 1, 1'b0, 1'b1, 25'h0000100);
        txn(1'b0, 25'h0000200, '0, LINE_K, 0, 0, 0, 0, 1, 1'b0, 1'b0, '0);
        check("err_stays", 128'(errSticky), 128'(1));

        // Reset in the middle of a read after 4 beats.
        cReqValid = 1'b1; cRw = 1'b0; cAddr = 25'h1234567; cyc(); cReqValid = 1'b0;
        kReqReady = 1'b1; cyc(); kReqReady = 1'b0;
        for (int b = 0; b < 4; b++) begin
            kRdValid = 1'b1; kRdData = 16'(16'h5500 + b); cyc();
        end
        kRdValid = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        checkReset("midrst");
        cyc();
        Rst = 1'b0;
        cyc();
        txn(1'b1, 25'h0765432, LINE_K ^ ~LINE_A, '0, 1, 1, 1, 0, 1, 1'b0, 1'b1, 25'h0765430);
        check("post_rst_err", 128'(errSticky), 128'(0));

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            txn(1'($urandom), 25'($urandom), {$urandom(), $urandom(), $urandom(), $urandom()},
                {$urandom(), $urandom(), $urandom(), $urandom()},
                $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(1, 0),
                $urandom_range(3, 0), $urandom_range(2, 0), 1'b1, 1'b0, '0);
        end
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/sdram_line_adapter.md
Name: sdram_line_adapter

Overview:
Upstream front-end of the SDRAM controller in mem_ss. It accepts one 128-bit cache-line read or write from the memory subsystem and issues it to the controller as a single 8-beat sequential burst (Set2Burst mode, 16-bit beats). Write lines are serialized into beats; read beats are assembled back into a line. One request is outstanding at a time, and the block flags any controller-side protocol error.

Parameters:
DATA_W, 16, SDRAM beat width in bits.
BURST_LEN, 8, beats per line; must equal the burst length programmed by the controller.
ADDR_W, 25, SDRAM word address width: {row[12:0], bank[1:0], col[9:0]}.
LINE_W, DATA_W*BURST_LEN (128), line width; derived, not overridable.

Ports:
Clock  in  1  system clock, 133 MHz.
Rst  in  1  asynchronous, active-high reset.
core_req_valid  in  1  line request valid.
core_req_ready  out  1  adapter can accept a request.
core_req_rw  in  1  1 = write, 0 = read.
core_req_addr  in  ADDR_W  word address; low log2(BURST_LEN) bits ignored.
core_req_wr_line  in  LINE_W  write line; beat k = bits [16k+15:16k].
core_rsp_valid  out  1  response valid.
core_rsp_ready  in  1  response accepted.
core_rsp_rw  out  1  echo of the request's rw.
core_rsp_rd_line  out  LINE_W  assembled read line.
ctrl_req_valid  out  1  burst command to the controller.
ctrl_req_ready  in  1  controller is in IDLE_TOP and takes the command.
ctrl_rw  out  1  burst direction.
ctrl_addr  out  ADDR_W  burst start address, low 3 bits zero.
ctrl_wr_data  out  DATA_W  current write beat.
ctrl_wr_beat  in  1  controller consumed ctrl_wr_data this cycle.
ctrl_rd_valid  in  1  read beat valid this cycle.
ctrl_rd_data  in  DATA_W  read beat.
ctrl_done  in  1  one-cycle pulse when the controller reaches DONE_TOP.
err_sticky  out  1  protocol error seen; cleared only by Rst.

Behaviour:
- FSM states: S_IDLE, S_ISSUE, S_WR_BEATS, S_RD_BEATS, S_WAIT_DONE, S_RESP.
- Registered state: beat counter cnt[2:0], last-beat flag, done_seen, latched addr/rw/line.
- Reset (async, Rst=1): state=S_IDLE; cnt=0; done_seen=0; err_sticky=0; every output is 0 except core_req_ready=1. Latched line and core_rsp_rd_line are 0.
- S_IDLE:
  - core_req_ready=1.
  - On valid&ready, latch rw, addr with [2:0] forced to 0, and wr_line, then go to S_ISSUE.
  - core_req_ready is 0 in every other state, so the adapter takes no back-to-back requests.
- S_ISSUE:
  - ctrl_req_valid=1; ctrl_rw and ctrl_addr are driven from the latches.
  - Hold until ctrl_req_ready, then clear cnt and done_seen.
  - Next state is S_WR_BEATS if rw=1, else S_RD_BEATS.
  - ctrl_req_valid deasserts the cycle after acceptance.
- S_WR_BEATS:
  - ctrl_wr_data = line[16*cnt +: 16], combinational from cnt; beat 0 is presented the cycle the state is entered.
  - Each ctrl_wr_beat increments cnt.
  - On the 8th beat (cnt=7 & ctrl_wr_beat), set the last-beat flag.
- S_RD_BEATS:
  - Each ctrl_rd_valid writes ctrl_rd_data into rd_line[16*cnt +: 16] and increments cnt.
  - The 8th beat sets the last-beat flag.
- Exit from a beat state:
  - After the last beat, go to S_RESP if done_seen=1 or ctrl_done is high in the same cycle; otherwise go to S_WAIT_DONE.
  - S_WAIT_DONE goes to S_RESP on ctrl_done.
- S_RESP: core_rsp_valid=1. Hold core_rsp_rw and core_rsp_rd_line stable until core_rsp_ready, then go to S_IDLE. core_req_ready rises the next cycle.
- Write responses: core_rsp_rd_line holds its previous value and consumers must ignore it.
- cnt wraps from 7 to 0. No beat is accepted after the 8th.
- Protocol errors set err_sticky; the FSM continues normally.
  - ctrl_rd_valid outside S_RD_BEATS.
  - ctrl_wr_beat outside S_WR_BEATS.
  - ctrl_done in S_ISSUE or S_RESP.
  - ctrl_done in a beat state before the last beat. done_seen is still set in this case.
- Simultaneous ctrl_wr_beat and ctrl_rd_valid: only the one matching the current state is used; the other counts as an error.
- Latency:
  - Request handshake to ctrl_req_valid: 1 cycle.
  - ctrl_done to core_rsp_valid: 1 cycle.
- Reset mid-operation discards all state, including partial lines. The controller shares Rst and resets with this block.

Test Plan:
- Write line: request rw=1, addr=0x0123457, line=0x0007_0006_..._0000 (beat k = k) -> ctrl_addr=0x0123450, ctrl_wr_data=0..7 across 8 ctrl_wr_beat pulses; ctrl_done -> core_rsp_valid one cycle later, rw=1, err_sticky=0.
- Read line: beats 0xA000..0xA007 with ctrl_rd_valid gaps of 0–2 cycles -> core_rsp_rd_line=0xA007_A006_..._A000, core_rsp_rw=0.
- ctrl_done coinciding with the 8th read beat -> direct S_RESP, no S_WAIT_DONE cycle, core_rsp_valid next cycle.
- Backpressure: ctrl_req_ready low 5 cycles and core_rsp_ready low 4 cycles -> ctrl_req_valid, ctrl_addr, core_rsp_valid and rd_line stay stable; core_req_ready=0 throughout.
- Protocol error: ctrl_rd_valid pulse while in S_IDLE, then ctrl_done after 3 write beats -> err_sticky=1 and stays 1 after later clean transactions until Rst.
- Assert Rst after 4 read beats -> all outputs back to their reset values asynchronously; the following write transaction completes correctly.
